multi_stream_sink: RTL

Multi-channel, synthesizable capture sink for AM-side valid/ready streams. It is the parametrised successor to the single-channel stream sink. CHANNELS producers are round-robin arbitrated into one shared capture memory. Each entry is tagged with its source channel. The memory runs in stop-on-full or ring (keep-latest) mode, and a registered readback port lets the bench or an on-chip checker inspect the memory without file I/O.

---
 rtl/multi_stream_sink.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/multi_stream_sink.sv
// multi_stream_sink
//   Multi-channel capture sink for valid/ready streams. CHANNELS producers are
//   round-robin arbitrated into one shared capture memory; every entry is
//   stored as {channel, data}. The memory either stops when full (WRAP=0) or
//   behaves as a ring that keeps the latest DEPTH entries (WRAP=1). A
//   registered readback port addresses entries by logical index (0 = oldest).
//
//   Handshake: a transfer on channel c happens in a cycle where both
//   iValid_AM[c] and oReady_AM[c] are high at the rising edge. oReady_AM is
//   one-hot or zero and depends combinationally on iValid_AM. Producers must
//   keep valid and data stable until the transfer happens.
//
//   Optional feature macro: STREAM_SINK_STALL_EN. When defined, a 16-bit
//   Fibonacci LFSR (taps 16,14,13,11; seed 16'hACE1) stalls every cycle in
//   which lfsr[0]=1, to exercise upstream backpressure.
//
// Ports
//   iCLK       clock, rising edge
//   iRST       asynchronous active-low reset
//   iValid_AM  per-channel valid             [CHANNELS]
//   oReady_AM  per-channel ready, one-hot/0  [CHANNELS]
//   iData_AM   channel c at [c*WIDTH +: WIDTH]
//   iStop      sticky freeze request
//   iRdAddr    logical read index            [AW]
//   oRdData    {channel, data} at iRdAddr, 1-cycle latency [CW+WIDTH]
//   oCount     stored entries, saturating at DEPTH [AW+1]
//   oOverflow  sticky, ring mode overwrote an entry
//   oEnd       capture finished (DONE state); doubles as the state debug view

module multi_stream_sink #(
    parameter int CHANNELS = 4,
    parameter int WIDTH    = 8,
    parameter int DEPTH    = 256,
    parameter int WRAP     = 0,
    localparam int CW      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
    localparam int AW      = $clog2(DEPTH)
) (
    input  logic                      iCLK,
    input  logic                      iRST,
    input  logic [CHANNELS-1:0]       iValid_AM,
    output logic [CHANNELS-1:0]       oReady_AM,
    input  logic [CHANNELS*WIDTH-1:0] iData_AM,
    input  logic                      iStop,
    input  logic [AW-1:0]             iRdAddr,
    output logic [CW+WIDTH-1:0]       oRdData,
    output logic [AW:0]               oCount,
    output logic                      oOverflow,
    output logic                      oEnd
);

    typedef enum logic {
        CAPTURE = 1'b0,
        DONE    = 1'b1
    } state_t;

    state_t            state;
    logic [CW-1:0]     rr_ptr;
    logic [AW-1:0]     wptr;
    logic [AW:0]       count;
    logic              overflow;
    logic              stall;
    logic              full;
    logic              grant_en;
    logic              grant_found;
    logic [CW-1:0]     grant_idx;
    logic [CW-1:0]     cand;
    logic [CHANNELS-1:0] ready_vec;
    logic              xfer;
    logic [WIDTH-1:0]  grant_data;
    logic [AW-1:0]     rd_base;
    logic [AW-1:0]     rd_phys;

    logic [CW+WIDTH-1:0] mem [DEPTH];

    // (base + off) mod CHANNELS for off < CHANNELS; CHANNELS need not be a power of two.
    function automatic logic [CW-1:0] wrap_idx(input int base, input int off);
        int s;
        s = base + off;
        if (s >= CHANNELS) s = s - CHANNELS;
        return CW'(s);
    endfunction

`ifdef STREAM_SINK_STALL_EN
    logic [15:0] lfsr;

    // Right-shifting Fibonacci form: feedback from bits 0,2,3,5 enters at bit 15.
    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) lfsr <= 16'hACE1;
        else       lfsr <= {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};
    end

    assign stall = lfsr[0];
`else
    assign stall = 1'b0;
`endif

    assign full = (count == (AW+1)'(DEPTH));

    // Ready is gated by iRST so nothing can handshake while reset is held.
    // In stop mode a full memory blocks grants in the same cycle, before DONE.
    assign grant_en = iRST && (state == CAPTURE) && !stall && !((WRAP == 0) && full);

    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            cand = wrap_idx(int'(rr_ptr), i);
            if (!grant_found && iValid_AM[cand]) begin
                grant_found = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    always_comb begin
        ready_vec = '0;
        if (grant_en && grant_found) ready_vec[grant_idx] = 1'b1;
    end

    assign oReady_AM  = ready_vec;
    assign xfer       = grant_en && grant_found;
    assign grant_data = iData_AM[grant_idx*WIDTH +: WIDTH];

    // Once the ring has wrapped, the oldest entry sits at the write pointer.
    assign rd_base = ((WRAP != 0) && full) ? wptr : '0;
    assign rd_phys = rd_base + iRdAddr;

    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            state    <= CAPTURE;
            rr_ptr   <= '0;
            wptr     <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (xfer) begin
                rr_ptr <= wrap_idx(int'(grant_idx), 1);
                wptr   <= wptr + 1'b1;
                if (!full)          count    <= count + 1'b1;
                else if (WRAP != 0) overflow <= 1'b1;
            end
            case (state)
                CAPTURE: begin
                    if (iStop || ((WRAP == 0) && xfer && (count == (AW+1)'(DEPTH - 1))))
                        state <= DONE;
                end
                DONE:    state <= DONE;
                default: state <= CAPTURE;
            endcase
        end
    end

    // Capture memory is intentionally not reset.
    always_ff @(posedge iCLK) begin
        if (xfer) mem[wptr] <= {grant_idx, grant_data};
    end

    // Registered readback; a same-edge write to this address returns old content.
    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) oRdData <= '0;
        else       oRdData <= mem[rd_phys];
    end

    assign oCount    = count;
    assign oOverflow = overflow;
    assign oEnd      = (state == DONE);

endmodule
